time_count_param: RTL and testbench
===================================

Name: time_count_param

Overview:
Parametrised elapsed-time counter and successor to the fixed 6-bit quarter-second counter.
- Counts qualified tick pulses in a sub-unit prescaler, then counts whole units.
- Either saturates or wraps at a configurable maximum.
- Flags terminal count and a programmable threshold crossing.
- Sits between the tick generator and the display/game-control logic.

Parameters:
TICKS_PER_UNIT, 4, ticks per counted unit (4 = quarter-second ticks per second); legal range >= 2
UNIT_W, 4, width of the unit count
MAX_UNITS, 15, last unit value before saturate/wrap; legal range <= 2^UNIT_W - 1
WRAP, 0, 0 = saturate at terminal count, 1 = roll over to zero

Ports:
clk  input  1  system clock, all state on rising edge
R_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear of the counters
run  input  1  count enable
tick  input  1  one-cycle count pulse (e.g. qsec)
thresh  input  UNIT_W  threshold compared against time_units
time_units  output  UNIT_W  whole units elapsed, registered
sub_count  output  max(1,$clog2(TICKS_PER_UNIT))  ticks within the current unit, registered
tc  output  1  level; high while at terminal count (time_units==MAX_UNITS and sub_count==TICKS_PER_UNIT-1)
match_p  output  1  one-cycle pulse when time_units increments to a value equal to thresh
wrap_p  output  1  one-cycle pulse on rollover (WRAP=1 only; tied 0 when WRAP=0)

Behaviour:
- R_n low (asynchronous): time_units=0, sub_count=0, match_p=0, wrap_p=0; tc follows the zero state.
- Priority per edge: clr > count > hold.
- clr=1: time_units=0, sub_count=0, match_p=0, wrap_p=0, regardless of tick/run.
- Count event = tick & run & ~clr.
  - sub_count < TICKS_PER_UNIT-1: sub_count++.
  - Otherwise, if not at terminal count: sub_count=0, time_units++.
- Terminal count, WRAP=0:
  - A count event is ignored; state holds and tc stays 1.
  - This is equivalent to the qualified-enable saturation of the earlier counter.
- Terminal count, WRAP=1:
  - A count event sets time_units=0 and sub_count=0.
  - wrap_p=1 for the following cycle.
  - match_p only if thresh==0.
- Latency: outputs change on the edge where the count event is sampled; there is no extra pipeline stage.
- tc: combinational decode of the registered state.
- match_p:
  - Registered; high for exactly the cycle in which the new time_units value first equals thresh after an increment or wrap.
  - Clear, reset, and changes to thresh never generate match_p.
  - Holding at saturation does not re-pulse.
- tick while run=0: no effect on any state.
- tick held high for multiple cycles: counts once per cycle; there is no edge detect.
- Reset mid-count: counters return to zero immediately; no pending pulses survive.

Optional Feature:
Macro TIME_COUNT_LAP_EN.
- Defined:
  - Adds input lap (1) and output lap_units (UNIT_W).
  - On a cycle with lap=1, lap_units captures time_units as it was before that edge's update.
  - If lap and a count event coincide, lap_units gets the pre-increment value.
  - lap_units resets to 0 on R_n, is NOT affected by clr, and holds otherwise.
- Undefined: ports lap/lap_units are absent; there is no extra logic.

Test Plan:
1. Defaults, run=1, 8 tick pulses from reset -> time_units=2, sub_count=0; match_p pulses on the edge time_units becomes thresh=2.
2. Defaults WRAP=0, 70 ticks -> time_units=15, sub_count=3, tc=1 from tick 63 onward; no further change; wrap_p never asserted.
3. WRAP=1, MAX_UNITS=9, TICKS_PER_UNIT=4, 40 ticks -> wrap_p single pulse at tick 40; time_units=0, sub_count=0, tc=0.
4. Count to time_units=5, then clr and tick on the same cycle -> time_units=0, sub_count=0, no match_p even with thresh=0; run=0 with 10 ticks -> no change.
5. Assert R_n low asynchronously mid-unit (time_units=3, sub_count=2), between clock edges -> all outputs 0 before the next edge; counting resumes from 0 after release.
6. TIME_COUNT_LAP_EN defined, lap coincident with the tick that moves 3->4 -> lap_units=3, time_units=4; a later clr leaves lap_units=3.

Source files
------------

// File: rtl/time_count_param.sv
// time_count_param: prescaled elapsed-unit counter, saturating or wrapping; lap capture under TIME_COUNT_LAP_EN
module time_count_param #(
  parameter int TICKS_PER_UNIT = 4,
  parameter int UNIT_W = 4,
  parameter int MAX_UNITS = 15,
  parameter bit WRAP = 1'b0,
  localparam int SUB_W = ($clog2(TICKS_PER_UNIT) > 1) ? $clog2(TICKS_PER_UNIT) : 1
) (
  input  logic              clk,
  input  logic              R_n,
  input  logic              clr,
  input  logic              run,
  input  logic              tick,
  input  logic [UNIT_W-1:0] thresh,
  output logic [UNIT_W-1:0] time_units,
  output logic [SUB_W-1:0]  sub_count,
  output logic              tc,
  output logic              match_p,
`ifdef TIME_COUNT_LAP_EN
  input  logic              lap,
  output logic [UNIT_W-1:0] lap_units,
`endif
  output logic              wrap_p
);
  logic [UNIT_W-1:0] units_q, units_d, units_inc;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic              match_q, match_d, wrap_q, wrap_d, cnt, sub_last;
  assign units_inc = units_q + 1'b1;
  assign sub_last  = sub_q == SUB_W'(TICKS_PER_UNIT - 1);
  assign tc        = sub_last && (units_q == UNIT_W'(MAX_UNITS));
  assign cnt       = tick & run & ~clr;
  // At terminal count a saturating counter simply falls through to hold
  always_comb begin
    units_d = units_q;
    sub_d   = sub_q;
    match_d = 1'b0;
    wrap_d  = 1'b0;
    if (clr) begin
      units_d = '0;
      sub_d   = '0;
    end else if (cnt && !sub_last) begin
      sub_d = sub_q + 1'b1;
    end else if (cnt && !tc) begin
      sub_d   = '0;
      units_d = units_inc;
      match_d = units_inc == thresh;
    end else if (cnt && WRAP) begin
      units_d = '0;
      sub_d   = '0;
      wrap_d  = 1'b1;
      match_d = thresh == '0;
    end
  end
  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      units_q <= '0;
      sub_q   <= '0;
      match_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      units_q <= units_d;
      sub_q   <= sub_d;
      match_q <= match_d;
      wrap_q  <= wrap_d;
    end
  end
`ifdef TIME_COUNT_LAP_EN
  logic [UNIT_W-1:0] lap_q;
  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) lap_q <= '0;
    else if (lap) lap_q <= units_q;
  end
  assign lap_units = lap_q;
`endif
  assign time_units = units_q;
  assign sub_count  = sub_q;
  assign match_p    = match_q;
  assign wrap_p     = WRAP && wrap_q;
endmodule

// File: tb/tb_time_count_param.sv
// tb_time_count_param: random and directed checks of a saturating and a wrapping instance against a tick-total model
module tb_time_count_param;
  logic clk = 1'b0, R_n = 1'b0, clr = 1'b0, run = 1'b0, tick = 1'b0, lap = 1'b0;
  logic [3:0] thresh = '0;
  logic [3:0] tu0, tu1;
  logic [1:0] sc0, sc1;
  logic tc0, tc1, mo0, mo1, wo0, wo1;
  int n0, n1, tests, fails;
  logic mp0, wp0, mp1, wp1;
  logic [3:0] lap_exp;
  logic [17:0] obs;
  localparam int T0 = 63;
  localparam int T1 = 39;
`ifdef TIME_COUNT_LAP_EN
  logic [3:0] lu0, lu1;
`endif

  time_count_param d0 (
    .clk(clk), .R_n(R_n), .clr(clr), .run(run), .tick(tick), .thresh(thresh),
    .time_units(tu0), .sub_count(sc0), .tc(tc0), .match_p(mo0),
`ifdef TIME_COUNT_LAP_EN
    .lap(lap), .lap_units(lu0),
`endif
    .wrap_p(wo0));

  time_count_param #(.TICKS_PER_UNIT(4), .UNIT_W(4), .MAX_UNITS(9), .WRAP(1'b1)) d1 (
    .clk(clk), .R_n(R_n), .clr(clr), .run(run), .tick(tick), .thresh(thresh),
    .time_units(tu1), .sub_count(sc1), .tc(tc1), .match_p(mo1),
`ifdef TIME_COUNT_LAP_EN
    .lap(lap), .lap_units(lu1),
`endif
    .wrap_p(wo1));

  always #5 clk = ~clk;
  assign obs = {tu0, sc0, tc0, mo0, wo0, tu1, sc1, tc1, mo1, wo1};

  // Model state is the total tick count since the last clear; units and sub-count are derived by division
  function automatic logic [17:0] expv();
    return {4'(n0 / 4), 2'(n0 % 4), n0 == T0, mp0, wp0, 4'(n1 / 4), 2'(n1 % 4), n1 == T1, mp1, wp1};
  endfunction

  task automatic model_zero();
    n0 = 0; n1 = 0; mp0 = 0; wp0 = 0; mp1 = 0; wp1 = 0;
  endtask

  task automatic cycle(input logic c, input logic r, input logic t, input logic l);
    clr = c; run = r; tick = t; lap = l;
    @(posedge clk);
    if (l) lap_exp = 4'(n0 / 4);
    mp0 = 0; wp0 = 0; mp1 = 0; wp1 = 0;
    if (c) model_zero();
    else if (r && t) begin
      if (n0 < T0) begin
        n0++;
        mp0 = (n0 % 4 == 0) && (n0 / 4 == int'(thresh));
      end
      if (n1 == T1) begin
        n1 = 0; wp1 = 1; mp1 = thresh == 0;
      end else begin
        n1++;
        mp1 = (n1 % 4 == 0) && (n1 / 4 == int'(thresh));
      end
    end
    #1;
  endtask

  task automatic test_reset();
    model_zero(); lap_exp = 0;
    #12;
    tests++;
    if (obs !== expv()) begin fails++; $display("FAIL reset: got %h expected %h", obs, expv()); end
    R_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_count();
    thresh = 4'd2;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 1, 0);
      tests++;
      if (obs !== expv()) begin fails++; $display("FAIL count tick%0d: got %h expected %h", i + 1, obs, expv()); end
    end
  endtask

  task automatic test_saturate();
    thresh = 4'd15;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 70; i++) begin
      cycle(0, 1, 1, 0);
      tests++;
      if (obs !== expv()) begin fails++; $display("FAIL saturate tick%0d: got %h expected %h", i + 1, obs, expv()); end
    end
  endtask

  task automatic test_wrap();
    thresh = 4'd0;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 42; i++) begin
      cycle(0, 1, 1, 0);
      tests++;
      if (obs !== expv()) begin fails++; $display("FAIL wrap tick%0d: got %h expected %h", i + 1, obs, expv()); end
    end
  endtask

  task automatic test_clr_run();
    thresh = 4'd0;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 1, 1, 0);
    tests++;
    if (obs !== expv()) begin fails++; $display("FAIL pre_clr: got %h expected %h", obs, expv()); end
    cycle(1, 1, 1, 0);
    tests++;
    if (obs !== expv()) begin fails++; $display("FAIL clr_tick: got %h expected %h", obs, expv()); end
    cycle(0, 1, 1, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 1, 0);
      tests++;
      if (obs !== expv()) begin fails++; $display("FAIL run_gate%0d: got %h expected %h", i, obs, expv()); end
    end
  endtask

  task automatic test_async_reset();
    thresh = 4'd9;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 14; i++) cycle(0, 1, 1, 0);
    tests++;
    if (obs !== expv()) begin fails++; $display("FAIL pre_reset: got %h expected %h", obs, expv()); end
    #2 R_n = 1'b0;
    #1 model_zero(); lap_exp = 0;
    tests++;
    if (obs !== expv()) begin fails++; $display("FAIL async_reset: got %h expected %h", obs, expv()); end
    #2 R_n = 1'b1;
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 1, 0);
      tests++;
      if (obs !== expv()) begin fails++; $display("FAIL resume%0d: got %h expected %h", i, obs, expv()); end
    end
  endtask

  task automatic test_lap();
`ifdef TIME_COUNT_LAP_EN
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 15; i++) cycle(0, 1, 1, 0);
    cycle(0, 1, 1, 1);
    tests++;
    if (lu0 !== 4'd3 || tu0 !== 4'd4) begin fails++; $display("FAIL lap_capture: got lap=%0d units=%0d expected lap=3 units=4", lu0, tu0); end
    cycle(1, 0, 0, 0);
    tests++;
    if (lu0 !== 4'd3 || tu0 !== 4'd0) begin fails++; $display("FAIL lap_clr: got lap=%0d units=%0d expected lap=3 units=0", lu0, tu0); end
`endif
  endtask

  task automatic test_random();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) thresh = 4'($urandom_range(0, 15));
      cycle($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
      tests++;
      if (obs !== expv()) begin fails++; $display("FAIL random%0d: got %h expected %h", i, obs, expv()); end
`ifdef TIME_COUNT_LAP_EN
      tests++;
      if (lu0 !== lap_exp) begin fails++; $display("FAIL random_lap%0d: got %0d expected %0d", i, lu0, lap_exp); end
`endif
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    test_reset();
    test_count();
    test_saturate();
    test_wrap();
    test_clr_run();
    test_async_reset();
    test_lap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
